dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 5, data memory word-address width.
REQ-002 Parameter DW, default 32, data word width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with ports in this order:
- clk  in  1  rising-edge clock shared with the data memory.
- rst  in  1  synchronous active-high reset.
- p0_req  in  1  port 0 (CPU load/store) request; held high until p0_gnt is seen.
- p0_we  in  1  port 0: 1 = write, 0 = read; valid with p0_req.
- p0_addr  in  AW  port 0 word address.
- p0_wdata  in  DW  port 0 write data.
- p0_gnt  out  1  port 0 request accepted; one-cycle pulse.
- p0_rvalid  out  1  port 0 transaction complete; one-cycle pulse; p0_rdata valid for reads.
- p0_rdata  out  DW  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1 (debug/loader).
- mem_read  out  1  drives data memory MemRead.
- mem_write  out  1  drives data memory MemWrite; memory commits on rising clk.
- mem_addr  out  AW  drives data memory addr.
- mem_wdata  out  DW  drives data memory data_in.
- mem_rdata  in  DW  data memory data_out (combinational read).
- busy  out  1  high while state is ACCESS.

Function
REQ-004 The FSM SHALL have two states: IDLE and ACCESS.
REQ-005 IDLE, no req high: remain in IDLE; all gnt outputs 0.
REQ-006 IDLE, one or both req high at a rising edge: select a winner, latch its we/addr/wdata, pulse its gnt high for the next cycle, and go to ACCESS.
REQ-007 Arbitration SHALL be round-robin on a 1-bit priority pointer:
- Single requester always wins.
- When both request, the port named by the pointer wins.
- After any grant, the pointer names the other port.
REQ-008 ACCESS SHALL last exactly one cycle and drive the memory outputs as follows:
- mem_addr and mem_wdata = latched values.
- mem_read = ~we.
- mem_write = we & ~rst.
REQ-009 Outside ACCESS, mem_read and mem_write SHALL be 0; mem_addr and mem_wdata SHALL hold their last latched values.
REQ-010 At the rising edge ending ACCESS, the block SHALL:
- for a read, capture mem_rdata into the winner's rdata register;
- pulse the winner's rvalid for the following cycle;
- return to IDLE.
REQ-011 The loser's rdata SHALL be unchanged; on a write, the winner's rdata SHALL also be unchanged.
REQ-012 Timing: req sampled at edge T; gnt high in cycle T..T+1 (ACCESS); memory access at edge T+1; rvalid high in cycle T+1..T+2; next arbitration at edge T+2. Peak throughput is one access per 2 cycles.
REQ-013 A req still high at the first IDLE edge after its gnt SHALL be treated as a new request (requesters drop req on seeing gnt).
REQ-014 A change of req/we/addr/wdata after a grant SHALL have no effect on the transaction in flight.
REQ-015 rvalid and gnt SHALL never be high for both ports in the same cycle.
REQ-016 With both ports requesting continuously, grants SHALL alternate 0,1,0,1,..., so neither port waits more than one transaction.

Reset
REQ-017 rst high at a rising edge SHALL force the following:
- state = IDLE and priority pointer = port 0;
- p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, busy, mem_read and mem_write = 0;
- p0_rdata, p1_rdata, mem_addr and mem_wdata = 0.
REQ-018 rst high during an ACCESS cycle SHALL abort the transaction:
- mem_write is suppressed in that cycle, so memory is not modified;
- no rvalid is issued;
- no rdata is updated.
REQ-019 Requests present while rst is high SHALL be ignored; arbitration resumes at the first edge with rst low.

Verification
REQ-020 Memory preloaded 0:17, 1:9, 2:25; p0 read addr 2 -> p0_gnt 1 cycle later, p0_rvalid 2 cycles after sampling with p0_rdata=25; p1 outputs quiet.
REQ-021 p1 write addr 3 data 0xDEADBEEF, then p0 read addr 3 -> mem_write high exactly one cycle; p0_rdata=0xDEADBEEF.
REQ-022 Both ports read continuously from reset (p0 addr 0, p1 addr 1) -> grants p0,p1,p0,p1; p0_rdata=17, p1_rdata=9; busy toggles every cycle.
REQ-023 p0 write addr 0 data 5, rst asserted during its ACCESS cycle -> mem_write low; no rvalid; after reset, a read of addr 0 returns 17.
REQ-024 p1 requests alone three times back to back -> each granted in turn with no wait on the pointer; a subsequent simultaneous request is won by p0.
REQ-025 p0 changes addr and wdata in the cycle after its gnt -> memory sees the originally latched addr and wdata.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each access takes an IDLE (arbitrate) cycle and an ACCESS (memory) cycle.
module dmem_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic          p0_gnt,
   output logic          p0_rvalid,
   output logic [DW-1:0] p0_rdata,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic          p1_gnt,
   output logic          p1_rvalid,
   output logic [DW-1:0] p1_rdata,
   output logic          mem_read,
   output logic          mem_write,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   typedef enum logic {StIdle, StAccess} state_t;

   state_t state_q;
   logic   ptr_q;
   logic   sel_q;
   logic   we_q;
   logic   win;

   // Pointer only matters on a tie; a lone requester always wins.
   always_comb begin
      if (p0_req && p1_req) win = ptr_q;
      else                  win = p1_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         ptr_q     <= 1'b0;
         sel_q     <= 1'b0;
         we_q      <= 1'b0;
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         p0_gnt    <= 1'b0;
         p1_gnt    <= 1'b0;
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (p0_req || p1_req) begin
                  sel_q     <= win;
                  ptr_q     <= ~win;
                  we_q      <= win ? p1_we : p0_we;
                  mem_addr  <= win ? p1_addr : p0_addr;
                  mem_wdata <= win ? p1_wdata : p0_wdata;
                  p0_gnt    <= ~win;
                  p1_gnt    <= win;
                  state_q   <= StAccess;
               end
            end
            StAccess: begin
               if (!we_q) begin
                  if (sel_q) p1_rdata <= mem_rdata;
                  else       p0_rdata <= mem_rdata;
               end
               p0_rvalid <= ~sel_q;
               p1_rvalid <= sel_q;
               state_q   <= StIdle;
            end
         endcase
      end
   end

   assign busy      = (state_q == StAccess);
   assign mem_read  = busy & ~we_q;
   // Gating with rst keeps an aborted write from reaching the memory.
   assign mem_write = busy & we_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level model with its own copy of memory contents.
module tb_dmem_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst;
   logic          p0_req, p0_we, p0_gnt, p0_rvalid;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata, p0_rdata;
   logic          p1_req, p1_we, p1_gnt, p1_rvalid;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata, p1_rdata;
   logic          mem_read, mem_write, busy;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      case (i)
         0:       return DW'(17);
         1:       return DW'(9);
         2:       return DW'(25);
         default: return DW'(32'h100 + i * 7);
      endcase
   endfunction

   // Data memory: commits on rising clk, combinational read.
   logic [DW-1:0] env_mem [2**AW];
   logic          preload;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2**AW; i++) env_mem[i] <= init_val(i);
      end else if (mem_write) begin
         env_mem[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = env_mem[mem_addr];

   int n_checks;
   int n_fail;
   int wr_cycles;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one transaction in flight at most, memory as an array.
   logic [DW-1:0] ref_mem [2**AW];
   logic          m_access, m_ptr, m_port, m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [1:0]    e_gnt, e_rvalid;
   logic [DW-1:0] e_rdata [2];

   task automatic model_edge();
      e_gnt    = 2'b00;
      e_rvalid = 2'b00;
      if (rst) begin
         m_access   = 1'b0;
         m_ptr      = 1'b0;
         m_we       = 1'b0;
         m_addr     = '0;
         m_wdata    = '0;
         e_rdata[0] = '0;
         e_rdata[1] = '0;
      end else if (m_access) begin
         if (m_we) ref_mem[m_addr] = m_wdata;
         else      e_rdata[m_port] = ref_mem[m_addr];
         e_rvalid[m_port] = 1'b1;
         m_access = 1'b0;
      end else if (p0_req || p1_req) begin
         m_port   = (p0_req && p1_req) ? m_ptr : p1_req;
         m_we     = m_port ? p1_we : p0_we;
         m_addr   = m_port ? p1_addr : p0_addr;
         m_wdata  = m_port ? p1_wdata : p0_wdata;
         m_ptr    = ~m_port;
         e_gnt[m_port] = 1'b1;
         m_access = 1'b1;
      end
   endtask

   task automatic check_comb();
      if (mem_write === 1'b1) wr_cycles++;
      check("mem_read", 64'(mem_read), 64'(m_access & ~m_we));
      check("mem_write", 64'(mem_write), 64'(m_access & m_we & ~rst));
      check("mem_addr", 64'(mem_addr), 64'(m_addr));
      check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
   endtask

   task automatic check_regs();
      check("p0_gnt", 64'(p0_gnt), 64'(e_gnt[0]));
      check("p1_gnt", 64'(p1_gnt), 64'(e_gnt[1]));
      check("p0_rvalid", 64'(p0_rvalid), 64'(e_rvalid[0]));
      check("p1_rvalid", 64'(p1_rvalid), 64'(e_rvalid[1]));
      check("p0_rdata", 64'(p0_rdata), 64'(e_rdata[0]));
      check("p1_rdata", 64'(p1_rdata), 64'(e_rdata[1]));
      check("busy", 64'(busy), 64'(m_access));
   endtask

   // Called just after a falling edge with inputs set for the next rising edge.
   task automatic tick();
      #1;
      check_comb();
      model_edge();
      @(negedge clk);
      check_regs();
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      p0_req = 1'b0;
      p1_req = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   int          n;
   int          w_before;
   logic [3:0]  gbits;

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      wr_cycles = 0;
      rst       = 1'b1;
      preload   = 1'b1;
      p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = init_val(i);
      model_edge();
      @(negedge clk);
      check_regs();
      preload = 1'b0;
      tick();
      rst = 1'b0;

      // Single p0 read of address 2.
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(2);
      tick();
      check("r020_gnt", 64'(p0_gnt), 64'd1);
      p0_req = 1'b0;
      tick();
      check("r020_rvalid", 64'(p0_rvalid), 64'd1);
      check("r020_rdata", 64'(p0_rdata), 64'd25);
      check("r020_p1_quiet", 64'({p1_gnt, p1_rvalid}), 64'd0);

      // p1 write then p0 read-back.
      wr_cycles = 0;
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = AW'(3); p1_wdata = 32'hDEADBEEF;
      tick();
      p1_req = 1'b0;
      tick();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(3);
      tick();
      p0_req = 1'b0;
      tick();
      check("r021_wr_cycles", 64'(wr_cycles), 64'd1);
      check("r021_rdata", 64'(p0_rdata), 64'hDEADBEEF);

      // Both ports reading continuously from reset.
      do_reset();
      gbits = 4'b0000;
      n = 0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(0);
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = AW'(1);
      for (int i = 0; i < 8; i++) begin
         tick();
         if (p0_gnt || p1_gnt) begin
            n++;
            gbits = {gbits[2:0], p1_gnt};
         end
      end
      p0_req = 1'b0; p1_req = 1'b0;
      check("r022_gnt_count", 64'(n), 64'd4);
      check("r022_gnt_order", 64'(gbits), 64'(4'b0101));
      check("r022_p0_rdata", 64'(p0_rdata), 64'd17);
      check("r022_p1_rdata", 64'(p1_rdata), 64'd9);
      tick();

      // Reset during a write's ACCESS cycle aborts it.
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = AW'(0); p0_wdata = DW'(5);
      tick();
      p0_req   = 1'b0;
      rst      = 1'b1;
      w_before = wr_cycles;
      tick();
      check("r023_no_write", 64'(wr_cycles), 64'(w_before));
      check("r023_no_rvalid", 64'(p0_rvalid), 64'd0);
      rst = 1'b0;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(0);
      tick();
      p0_req = 1'b0;
      tick();
      check("r023_rdata", 64'(p0_rdata), 64'd17);

      // p1 alone three times, then a tie goes to p0.
      n = 0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = AW'(1);
      for (int i = 0; i < 6; i++) begin
         tick();
         if (p1_gnt) n++;
      end
      check("r024_p1_grants", 64'(n), 64'd3);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(2);
      tick();
      check("r024_tie_p0", 64'({p1_gnt, p0_gnt}), 64'(2'b01));
      p0_req = 1'b0; p1_req = 1'b0;
      tick();

      // Inputs changed after grant must not affect the access.
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = AW'(4); p0_wdata = 32'hA5A50001;
      tick();
      p0_req = 1'b0; p0_addr = AW'(5); p0_wdata = 32'h00000BAD;
      #1;
      check("r025_addr", 64'(mem_addr), 64'd4);
      check("r025_wdata", 64'(mem_wdata), 64'hA5A50001);
      tick();
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = AW'(4);
      tick();
      p0_req = 1'b0;
      tick();
      check("r025_readback", 64'(p0_rdata), 64'hA5A50001);

      // Random traffic with occasional resets.
      for (int c = 0; c < 1500; c++) begin
         if (p0_gnt) begin
            p0_req   = 1'b0;
            p0_we    = 1'($urandom_range(0, 1));
            p0_addr  = AW'($urandom_range(0, 7));
            p0_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) p0_req = 1'b1;
         end else if (!p0_req && $urandom_range(0, 3) == 0) begin
            p0_req   = 1'b1;
            p0_we    = 1'($urandom_range(0, 1));
            p0_addr  = AW'($urandom_range(0, 7));
            p0_wdata = $urandom;
         end
         if (p1_gnt) begin
            p1_req   = 1'b0;
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = AW'($urandom_range(0, 7));
            p1_wdata = $urandom;
            if ($urandom_range(0, 1) == 1) p1_req = 1'b1;
         end else if (!p1_req && $urandom_range(0, 3) == 0) begin
            p1_req   = 1'b1;
            p1_we    = 1'($urandom_range(0, 1));
            p1_addr  = AW'($urandom_range(0, 7));
            p1_wdata = $urandom;
         end
         rst = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
